// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path.
// FSM states, ready-bit position and the idle/empty word.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int          UART_READY_BIT  = 15;
  localparam logic [15:0] UART_EMPTY_WORD = 16'h8000;

endpackage

// File: rtl/uart_byte_fifo.sv
// Generic 8-bit synchronous FIFO with a registered head view.
// Usable on both the RX and TX side of the UART.
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_nx;
  logic [AW:0]   cnt;
  logic [7:0]    head;
  logic [7:0]    head_n;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a byte when a pop frees a slot
  assign do_push = push && (!full || do_pop);
  assign rptr_nx = rptr + AW'(1);

  always_comb begin
    head_n = head;
    if (do_pop) begin
      if (cnt == CNT_ONE)
        head_n = do_push ? wdata : 8'h00;
      else
        head_n = mem[rptr_nx];
    end else if (do_push && empty) begin
      head_n = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      head <= 8'h00;
    end else begin
      if (do_push)
        wptr <= wptr + AW'(1);
      if (do_pop)
        rptr <= rptr_nx;
      if (do_push && !do_pop)
        cnt <= cnt + CNT_ONE;
      else if (do_pop && !do_push)
        cnt <= cnt - CNT_ONE;
      head <= head_n;
    end
  end

  assign rdata = head;
  assign count = cnt;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Arms UartRX, captures completed bytes into a FIFO and
// presents the FIFO head as a 16-bit memory-mapped word.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [15:0]   rx_out,
  output logic          rx_clear,
  input  logic          rd,
  output logic [15:0]   rd_data,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_overrun
);

  state_t     state;
  state_t     state_n;
  logic       push;
  logic       full;
  logic       empty;
  logic       drop;
  logic [7:0] head;
  logic       unused_rx_bits;

  assign unused_rx_bits = ^rx_out[14:8];

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (en) state_n = ARM;
      ARM:     state_n = WAIT;
      WAIT:    if (!rx_out[UART_READY_BIT]) state_n = CAPTURE;
      CAPTURE: state_n = en ? ARM : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rx_clear = (state == ARM);
  assign push     = (state == CAPTURE);
  // pop wins the slot when full, so only a pop-less push is lost
  assign drop     = push && full && !rd;

  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
    else if (clr_overrun)
      overrun <= 1'b0;
  end

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (rd),
    .wdata (rx_out[7:0]),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rd_data = {empty, 7'b0, head};

endmodule
